// File: rtl/bullet_ctrl.sv
// Player-bullet pool manager: spawns a shot at the ship on a fire press,
// moves every live shot upward once per frame, retires shots flagged by the
// hit detector. All outputs come straight from registers.
module bullet_ctrl #(
  parameter int unsigned BulletCount    = 2,
  parameter int unsigned SpeedPx        = 6,
  parameter int unsigned SpawnY         = 440,
  parameter int unsigned XOffset        = 6,
  parameter int unsigned CooldownFrames = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_tick_i,
  input  logic                   enable_i,
  input  logic                   fire_i,
  input  logic [9:0]             player_xpos_i,
  input  logic                   bhit_i          [BulletCount],
  output logic [9:0]             bullet_xpos_o   [BulletCount],
  output logic [9:0]             bullet_ypos_o   [BulletCount],
  output logic [BulletCount-1:0] bullet_active_o,
  output logic [15:0]            shots_o
);

  localparam int unsigned CdW = (CooldownFrames > 0) ? $clog2(CooldownFrames + 1) : 1;

  localparam logic [9:0]     SpawnYW   = 10'(SpawnY);
  localparam logic [9:0]     XOffsetW  = 10'(XOffset);
  localparam logic [9:0]     SpeedW    = 10'(SpeedPx);
  localparam logic [9:0]     ParkY     = 10'd1023;
  localparam logic [CdW-1:0] CooldownW = CdW'(CooldownFrames);

  typedef enum logic {StIdle, StActive} slot_state_e;

  slot_state_e      state_q [BulletCount];
  slot_state_e      state_d [BulletCount];
  logic [9:0]       xpos_q  [BulletCount];
  logic [9:0]       xpos_d  [BulletCount];
  logic [9:0]       ypos_q  [BulletCount];
  logic [9:0]       ypos_d  [BulletCount];
  logic             pending_q, pending_d;
  logic             fire_prev_q;
  logic [CdW-1:0]   cooldown_q, cooldown_d;
  logic [15:0]      shots_q, shots_d;

  logic                   fire_rise;
  logic                   pending_eff;
  logic                   spawn;
  logic [BulletCount-1:0] free;
  logic [BulletCount-1:0] spawn_sel;

  // Spawn decision and shared counters; free mask is taken from registered state
  // so a slot retiring this cycle cannot be reused until next cycle.
  always_comb begin
    fire_rise   = fire_i & ~fire_prev_q;
    // An edge arriving together with the tick still counts for that tick.
    pending_eff = pending_q | fire_rise;
    for (int j = 0; j < BulletCount; j++) begin
      free[j] = (state_q[j] == StIdle);
    end
    // Isolate lowest set bit: lowest-index idle slot.
    spawn_sel = free & (~free + BulletCount'(1));
    spawn     = frame_tick_i & pending_eff & (cooldown_q == '0) & enable_i & (|free);

    pending_d  = pending_eff;
    cooldown_d = cooldown_q;
    shots_d    = shots_q;
    if (!enable_i) begin
      pending_d  = 1'b0;
      cooldown_d = '0;
    end else if (frame_tick_i) begin
      pending_d = 1'b0;
      if (spawn) begin
        cooldown_d = CooldownW;
        shots_d    = shots_q + 16'd1;
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - CdW'(1);
      end
    end
  end

  // Per-slot next state: disable > retire > move; spawn only into idle slots.
  always_comb begin
    for (int j = 0; j < BulletCount; j++) begin
      state_d[j] = state_q[j];
      xpos_d[j]  = xpos_q[j];
      ypos_d[j]  = ypos_q[j];
      if (!enable_i) begin
        state_d[j] = StIdle;
        xpos_d[j]  = '0;
        ypos_d[j]  = ParkY;
      end else begin
        unique case (state_q[j])
          StIdle: begin
            if (spawn && spawn_sel[j]) begin
              state_d[j] = StActive;
              xpos_d[j]  = player_xpos_i + XOffsetW;
              ypos_d[j]  = SpawnYW;
            end
          end
          StActive: begin
            if (bhit_i[j]) begin
              state_d[j] = StIdle;
              xpos_d[j]  = '0;
              ypos_d[j]  = ParkY;
            end else if (frame_tick_i) begin
              // Wraps on underflow; the hit detector retires it off-screen.
              ypos_d[j] = ypos_q[j] - SpeedW;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers; fire_prev resets high so a button held through reset is ignored.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int j = 0; j < BulletCount; j++) begin
        state_q[j] <= StIdle;
        xpos_q[j]  <= '0;
        ypos_q[j]  <= ParkY;
      end
      pending_q   <= 1'b0;
      fire_prev_q <= 1'b1;
      cooldown_q  <= '0;
      shots_q     <= '0;
    end else begin
      for (int j = 0; j < BulletCount; j++) begin
        state_q[j] <= state_d[j];
        xpos_q[j]  <= xpos_d[j];
        ypos_q[j]  <= ypos_d[j];
      end
      pending_q   <= pending_d;
      fire_prev_q <= fire_i;
      cooldown_q  <= cooldown_d;
      shots_q     <= shots_d;
    end
  end

  // Outputs driven directly from the registers.
  always_comb begin
    for (int j = 0; j < BulletCount; j++) begin
      bullet_xpos_o[j]   = xpos_q[j];
      bullet_ypos_o[j]   = ypos_q[j];
      bullet_active_o[j] = (state_q[j] == StActive);
    end
    shots_o = shots_q;
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl with default parameters (2 slots).
module tb_bullet_ctrl;

  logic       clk_i;
  logic       reset_i;
  logic       frame_tick_i;
  logic       enable_i;
  logic       fire_i;
  logic [9:0] player_xpos_i;
  logic       bhit_i          [2];
  logic [9:0] bullet_xpos_o   [2];
  logic [9:0] bullet_ypos_o   [2];
  logic [1:0] bullet_active_o;
  logic [15:0] shots_o;

  int checks = 0;
  int errors = 0;

  bullet_ctrl dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .frame_tick_i   (frame_tick_i),
    .enable_i       (enable_i),
    .fire_i         (fire_i),
    .player_xpos_i  (player_xpos_i),
    .bhit_i         (bhit_i),
    .bullet_xpos_o  (bullet_xpos_o),
    .bullet_ypos_o  (bullet_ypos_o),
    .bullet_active_o(bullet_active_o),
    .shots_o        (shots_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic fire_level);
    reset_i      = 1'b1;
    fire_i       = fire_level;
    frame_tick_i = 1'b0;
    enable_i     = 1'b1;
    bhit_i[0]    = 1'b0;
    bhit_i[1]    = 1'b0;
    #3;
    cycle();
    cycle();
    reset_i = 1'b0;
    cycle();
  endtask

  task automatic press();
    fire_i = 1'b1;
    cycle();
    fire_i = 1'b0;
    cycle();
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    cycle();
    frame_tick_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (bullet_active_o !== 2'b00) begin
      errors++; $display("FAIL reset_active: got %b want 00", bullet_active_o);
    end
    checks++;
    if (bullet_xpos_o[0] !== 10'd0) begin
      errors++; $display("FAIL reset_x0: got %0d want 0", bullet_xpos_o[0]);
    end
    checks++;
    if (bullet_ypos_o[0] !== 10'd1023 || bullet_ypos_o[1] !== 10'd1023) begin
      errors++; $display("FAIL reset_y: got %0d/%0d want 1023/1023",
                         bullet_ypos_o[0], bullet_ypos_o[1]);
    end
    checks++;
    if (shots_o !== 16'd0) begin
      errors++; $display("FAIL reset_shots: got %0d want 0", shots_o);
    end
  endtask

  task automatic test_first_spawn();
    do_reset(1'b0);
    player_xpos_i = 10'd100;
    press();
    tick();
    checks++;
    if (bullet_active_o !== 2'b01 || bullet_xpos_o[0] !== 10'd106 ||
        bullet_ypos_o[0] !== 10'd440) begin
      errors++; $display("FAIL spawn_slot0: got act=%b x=%0d y=%0d want 01/106/440",
                         bullet_active_o, bullet_xpos_o[0], bullet_ypos_o[0]);
    end
    checks++;
    if (shots_o !== 16'd1) begin
      errors++; $display("FAIL spawn_shots: got %0d want 1", shots_o);
    end
    tick();
    checks++;
    if (bullet_ypos_o[0] !== 10'd434) begin
      errors++; $display("FAIL move_y0: got %0d want 434", bullet_ypos_o[0]);
    end
    checks++;
    if (bullet_active_o[1] !== 1'b0 || bullet_ypos_o[1] !== 10'd1023) begin
      errors++; $display("FAIL move_slot1_idle: got act=%b y=%0d want 0/1023",
                         bullet_active_o[1], bullet_ypos_o[1]);
    end
  endtask

  // Press before every tick; cooldown allows spawns only on ticks 1 and 10.
  task automatic test_cooldown();
    do_reset(1'b0);
    player_xpos_i = 10'd100;
    for (int t = 1; t <= 19; t++) begin
      press();
      tick();
      if (t == 9) begin
        checks++;
        if (shots_o !== 16'd1 || bullet_active_o !== 2'b01) begin
          errors++; $display("FAIL cooldown_t9: got shots=%0d act=%b want 1/01",
                             shots_o, bullet_active_o);
        end
      end
      if (t == 10) begin
        checks++;
        if (shots_o !== 16'd2 || bullet_active_o !== 2'b11 ||
            bullet_ypos_o[1] !== 10'd440 || bullet_xpos_o[1] !== 10'd106) begin
          errors++; $display("FAIL cooldown_t10: got shots=%0d act=%b x1=%0d y1=%0d want 2/11/106/440",
                             shots_o, bullet_active_o, bullet_xpos_o[1], bullet_ypos_o[1]);
        end
      end
    end
    checks++;
    if (shots_o !== 16'd2) begin
      errors++; $display("FAIL pool_full_shots: got %0d want 2", shots_o);
    end
    checks++;
    if (bullet_ypos_o[0] !== 10'd332 || bullet_ypos_o[1] !== 10'd386) begin
      errors++; $display("FAIL pool_full_y: got %0d/%0d want 332/386",
                         bullet_ypos_o[0], bullet_ypos_o[1]);
    end
  endtask

  task automatic test_retire();
    do_reset(1'b0);
    player_xpos_i = 10'd100;
    press();
    tick();
    bhit_i[0] = 1'b1;
    cycle();
    bhit_i[0] = 1'b0;
    checks++;
    if (bullet_active_o !== 2'b00 || bullet_xpos_o[0] !== 10'd0 ||
        bullet_ypos_o[0] !== 10'd1023) begin
      errors++; $display("FAIL retire_park: got act=%b x=%0d y=%0d want 00/0/1023",
                         bullet_active_o, bullet_xpos_o[0], bullet_ypos_o[0]);
    end
    for (int i = 0; i < 8; i++) tick();
    // Rising edge in the same cycle as the tick.
    fire_i       = 1'b1;
    frame_tick_i = 1'b1;
    cycle();
    frame_tick_i = 1'b0;
    fire_i       = 1'b0;
    checks++;
    if (bullet_active_o !== 2'b01 || bullet_ypos_o[0] !== 10'd440 || shots_o !== 16'd2) begin
      errors++; $display("FAIL respawn_slot0: got act=%b y=%0d shots=%0d want 01/440/2",
                         bullet_active_o, bullet_ypos_o[0], shots_o);
    end
  endtask

  task automatic test_back_to_back();
    frame_tick_i = 1'b1;
    cycle();
    cycle();
    frame_tick_i = 1'b0;
    checks++;
    if (bullet_ypos_o[0] !== 10'd428) begin
      errors++; $display("FAIL b2b_ticks_y0: got %0d want 428", bullet_ypos_o[0]);
    end
  endtask

  // 440 is 2 mod 6, so the lowest on-screen Y reached is 2, then wraps to 1020.
  task automatic test_wrap();
    do_reset(1'b0);
    player_xpos_i = 10'd100;
    press();
    tick();
    for (int i = 0; i < 73; i++) tick();
    checks++;
    if (bullet_ypos_o[0] !== 10'd2 || bullet_active_o[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_pre: got y=%0d act=%b want 2/1",
                         bullet_ypos_o[0], bullet_active_o[0]);
    end
    tick();
    checks++;
    if (bullet_ypos_o[0] !== 10'd1020) begin
      errors++; $display("FAIL wrap_y: got %0d want 1020", bullet_ypos_o[0]);
    end
    bhit_i[0] = (bullet_ypos_o[0] > 10'd480);
    cycle();
    bhit_i[0] = 1'b0;
    checks++;
    if (bullet_active_o[0] !== 1'b0 || bullet_ypos_o[0] !== 10'd1023) begin
      errors++; $display("FAIL wrap_retire: got act=%b y=%0d want 0/1023",
                         bullet_active_o[0], bullet_ypos_o[0]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset(1'b0);
    player_xpos_i = 10'd100;
    press();
    tick();
    for (int i = 0; i < 8; i++) tick();
    press();
    player_xpos_i = 10'd1020;
    frame_tick_i  = 1'b1;
    bhit_i[0]     = 1'b1;
    cycle();
    frame_tick_i = 1'b0;
    bhit_i[0]    = 1'b0;
    checks++;
    if (bullet_active_o !== 2'b10 || bullet_ypos_o[0] !== 10'd1023) begin
      errors++; $display("FAIL same_retire: got act=%b y0=%0d want 10/1023",
                         bullet_active_o, bullet_ypos_o[0]);
    end
    checks++;
    if (bullet_xpos_o[1] !== 10'd2 || bullet_ypos_o[1] !== 10'd440 || shots_o !== 16'd2) begin
      errors++; $display("FAIL same_spawn_slot1: got x=%0d y=%0d shots=%0d want 2/440/2",
                         bullet_xpos_o[1], bullet_ypos_o[1], shots_o);
    end
  endtask

  task automatic test_held_fire_enable();
    do_reset(1'b1);
    player_xpos_i = 10'd50;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (shots_o !== 16'd0 || bullet_active_o !== 2'b00) begin
      errors++; $display("FAIL held_fire: got shots=%0d act=%b want 0/00",
                         shots_o, bullet_active_o);
    end
    fire_i = 1'b0;
    cycle();
    press();
    tick();
    checks++;
    if (shots_o !== 16'd1 || bullet_xpos_o[0] !== 10'd56) begin
      errors++; $display("FAIL held_then_press: got shots=%0d x=%0d want 1/56",
                         shots_o, bullet_xpos_o[0]);
    end
    enable_i = 1'b0;
    cycle();
    checks++;
    if (bullet_active_o !== 2'b00 || bullet_ypos_o[0] !== 10'd1023 || shots_o !== 16'd1) begin
      errors++; $display("FAIL disable: got act=%b y0=%0d shots=%0d want 00/1023/1",
                         bullet_active_o, bullet_ypos_o[0], shots_o);
    end
    // Disable also cleared cooldown, so an immediate press spawns.
    enable_i = 1'b1;
    cycle();
    press();
    tick();
    checks++;
    if (shots_o !== 16'd2 || bullet_active_o !== 2'b01) begin
      errors++; $display("FAIL cooldown_cleared: got shots=%0d act=%b want 2/01",
                         shots_o, bullet_active_o);
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    frame_tick_i  = 1'b0;
    enable_i      = 1'b1;
    fire_i        = 1'b0;
    player_xpos_i = 10'd0;
    bhit_i[0]     = 1'b0;
    bhit_i[1]     = 1'b0;
    test_reset();
    test_first_spawn();
    test_cooldown();
    test_retire();
    test_back_to_back();
    test_wrap();
    test_same_cycle();
    test_held_fire_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_ctrl.md
# bullet_ctrl

Player-bullet manager that owns the fixed pool of player shots. It spawns a bullet at the ship on a fire press and advances every live bullet once per video frame. It retires a bullet when the hit detector flags it. It sits directly upstream of the hit detector: it drives that stage's per-bullet X/Y positions and consumes its per-bullet hit flags.

## Interface
- BulletCount, 2, number of bullet slots; must match the hit detector.
- SpeedPx, 6, pixels moved upward per frame tick.
- SpawnY, 440, Y loaded into a slot on spawn.
- XOffset, 6, added to player X on spawn to centre the bullet on the ship.
- CooldownFrames, 8, frame ticks that must elapse after a spawn before the next spawn.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- frame_tick_i  in  1  one-cycle pulse per frame (end of active video).
- enable_i  in  1  game running; low retires all bullets.
- fire_i  in  1  fire button level, already synchronous to clk_i.
- player_xpos_i  in  10  ship left-edge X.
- bhit_i  in  1 x BulletCount (unpacked)  per-slot hit/off-screen flag from the hit detector.
- bullet_xpos_o  out  10 x BulletCount (unpacked)  slot X.
- bullet_ypos_o  out  10 x BulletCount (unpacked)  slot Y.
- bullet_active_o  out  BulletCount  slot live flag, used by the sprite renderer.
- shots_o  out  16  count of bullets spawned, wraps at 2^16.

## Operation
- Each slot is a two-state FSM, IDLE or ACTIVE.
- An IDLE slot parks at X=0, Y=1023. Y=1023 cannot intersect any enemy, and its bhit_i is ignored.
- Fire edge: fire_prev is registered. A rising edge (fire_i & ~fire_prev) sets the `pending` flag.
- fire_prev resets to 1, so a button held through reset does not fire.
- At frame_tick_i, spawn happens when all of these hold: pending=1, cooldown=0, enable_i=1, and at least one slot is IDLE in the registered state.
- Spawn target is the lowest-index IDLE slot. It goes ACTIVE with X = (player_xpos_i + XOffset) mod 1024 and Y = SpawnY.
- On spawn: cooldown loads CooldownFrames, shots_o increments, pending clears.
- pending is always cleared at frame_tick_i, whether or not a spawn happened. Presses are never queued beyond one frame.
- cooldown decrements by 1 at each frame_tick_i that does not spawn, while nonzero.
- Movement: at frame_tick_i every ACTIVE slot sets Y <= (Y - SpeedPx) mod 1024.
- Movement does not clamp. Underflow wraps above 480, the hit detector then flags the slot, and the slot retires.
- Retire: when bhit_i[j]=1 and slot j is ACTIVE, slot j goes IDLE and parks on the next clock.
- Simultaneous events in one cycle:
  - Retire beats movement on the same slot.
  - A slot retired in a cycle is not eligible for spawn in that cycle; the free mask comes from registered state.
  - A rising edge in the same cycle as frame_tick_i is counted for that tick.
- enable_i=0: all slots go IDLE next clock, pending clears, cooldown clears. shots_o holds.

## Timing
- Reset values: all slots IDLE, bullet_xpos_o=0, bullet_ypos_o=1023, bullet_active_o=0, shots_o=0, cooldown=0, pending=0, fire_prev=1.
- Reset is asynchronous and may assert mid-frame. It wins over every other event.
- All outputs are registered.
- Spawn and move results appear the cycle after frame_tick_i.
- bhit_i is combinational in the hit detector from the current outputs, so a collision at cycle N retires the slot at the edge ending cycle N, one cycle after the position update.
- Minimum spacing between spawns is CooldownFrames+1 frame ticks.
- frame_tick_i on consecutive cycles is legal; each pulse is a full tick.

## Test plan
- Reset, then fire rising edge with player_xpos_i=100, then tick:
  - slot0 ACTIVE, X=106, Y=440; shots_o=1.
  - Next tick: Y=434; slot1 IDLE, Y=1023.
- Fire press before every tick with defaults:
  - Spawns on tick 1 and tick 10 only, and the tick-10 spawn fills slot1.
  - A third spawn (tick 19) is refused because both slots are ACTIVE.
- Drive bhit_i[0]=1 for one cycle on ACTIVE slot0:
  - Next cycle slot0 is IDLE, X=0, Y=1023.
  - A press plus tick then re-spawns into slot0.
- Wrap: slot at Y=4, tick:
  - Y=1022.
  - Bench asserts bhit_i (Y>480), and the slot is IDLE the following cycle.
- Same cycle: frame_tick_i, bhit_i[0]=1, pending=1, slot1 IDLE, cooldown=0:
  - slot0 retires without moving.
  - The spawn goes to slot1, not slot0.
- Fire held high through reset deassertion, no further edges, 3 ticks:
  - No spawn.
  - Then drop enable_i with slots active: all slots IDLE next cycle, shots_o unchanged.
